// File: rtl/alu_result_collector_pkg.sv
// Shared definitions for the ALU result collector: source tags and tag type.
package alu_result_collector_pkg;

  typedef logic [1:0] tag_t;

  localparam tag_t TAG_ARITH = 2'd0;
  localparam tag_t TAG_LOGIC = 2'd1;
  localparam tag_t TAG_CMP   = 2'd2;
  localparam tag_t TAG_SHIFT = 2'd3;

endpackage

// File: rtl/alu_res_fifo.sv
// Small synchronous FIFO holding {tag, result} entries with a combinational head read.
module alu_res_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    pop_ok   = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/alu_result_collector.sv
// Collects results from four ALU units by fixed priority into a FIFO, counting
// dropped results and flagging cycles where more than one unit reported.
module alu_result_collector
  import alu_result_collector_pkg::*;
#(
  parameter int RES_WIDTH = 16,
  parameter int DEPTH     = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [RES_WIDTH-1:0]   Arith_OUT,
  input  logic [RES_WIDTH-1:0]   Logic_OUT,
  input  logic [RES_WIDTH-1:0]   CMP_OUT,
  input  logic [RES_WIDTH-1:0]   Shift_OUT,
  input  logic                   Arith_Flag,
  input  logic                   Logic_Flag,
  input  logic                   CMP_Flag,
  input  logic                   Shift_Flag,
  output logic [RES_WIDTH-1:0]   OUT_DATA,
  output tag_t                   OUT_TAG,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [$clog2(DEPTH):0] Count,
  output logic [7:0]             Drop_Cnt,
  output logic                   Multi_Err
);

  localparam int EW = RES_WIDTH + 2;

  logic [RES_WIDTH-1:0] sel_data;
  tag_t                 sel_tag;
  logic [2:0]           n_flags;
  logic                 push, pop;
  logic                 fifo_full, fifo_empty;
  logic [EW-1:0]        fifo_dout;
  logic [7:0]           drop_cnt_q, drop_cnt_d;
  logic                 multi_err_q, multi_err_d;

  always_comb begin
    sel_tag  = TAG_ARITH;
    sel_data = Arith_OUT;
    if (Arith_Flag) begin
      sel_tag  = TAG_ARITH;
      sel_data = Arith_OUT;
    end else if (Logic_Flag) begin
      sel_tag  = TAG_LOGIC;
      sel_data = Logic_OUT;
    end else if (CMP_Flag) begin
      sel_tag  = TAG_CMP;
      sel_data = CMP_OUT;
    end else if (Shift_Flag) begin
      sel_tag  = TAG_SHIFT;
      sel_data = Shift_OUT;
    end
  end

  always_comb begin
    n_flags     = 3'(Arith_Flag) + 3'(Logic_Flag) + 3'(CMP_Flag) + 3'(Shift_Flag);
    push        = (n_flags != 3'd0) && !RST;
    pop         = !fifo_empty && OUT_READY;
    multi_err_d = multi_err_q || (n_flags > 3'd1);
    drop_cnt_d  = drop_cnt_q;
    if (push && fifo_full && !pop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      drop_cnt_q  <= '0;
      multi_err_q <= 1'b0;
    end else begin
      drop_cnt_q  <= drop_cnt_d;
      multi_err_q <= multi_err_d;
    end
  end

  alu_res_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .din   ({sel_tag, sel_data}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (Count)
  );

  // Storage is never reset, so the head is masked to zero whenever the FIFO is empty.
  assign OUT_VALID = !fifo_empty;
  assign OUT_DATA  = fifo_empty ? '0 : fifo_dout[RES_WIDTH-1:0];
  assign OUT_TAG   = fifo_empty ? TAG_ARITH : tag_t'(fifo_dout[EW-1:RES_WIDTH]);
  assign Drop_Cnt  = drop_cnt_q;
  assign Multi_Err = multi_err_q;

endmodule

// File: doc/alu_result_collector.md
ALU_RESULT_COLLECTOR -- requirements
Module: alu_result_collector

Interface
REQ-001 Parameter RES_WIDTH, default 16: width of every unit result and of OUT_DATA.
REQ-002 Parameter DEPTH, default 4: result FIFO entries; power of two, minimum 2.
REQ-003 The block SHALL use one clock, CLK, and a synchronous, active-high reset, RST.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT  input  RES_WIDTH each  registered unit results.
REQ-007 Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag  input  1 each  result-valid flag, one per unit.
REQ-008 OUT_DATA  output  RES_WIDTH  result at the FIFO head.
REQ-009 OUT_TAG  output  2  source unit of the head entry: 0 arith, 1 logic, 2 cmp, 3 shift.
REQ-010 OUT_VALID  output  1  FIFO non-empty.
REQ-011 OUT_READY  input  1  consumer accepts the head entry.
REQ-012 Count  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 Drop_Cnt  output  8  saturating count of results lost to a full FIFO.
REQ-014 Multi_Err  output  1  sticky; more than one flag was seen in a cycle.

Function
REQ-015 A push SHALL occur in any cycle where at least one flag is high.
REQ-016 Source selection SHALL follow fixed priority arith > logic > cmp > shift; only the selected result and its tag are pushed.
REQ-017 Two or more flags high in one cycle SHALL set Multi_Err, which holds until RST.
REQ-018 A pop SHALL occur when OUT_VALID and OUT_READY are both high at a rising edge.
REQ-019 Latency: a result pushed into an empty FIFO at edge N SHALL appear on OUT_DATA/OUT_TAG with OUT_VALID=1 after edge N (zero bypass, one-cycle latency).
REQ-020 OUT_DATA/OUT_TAG SHALL stay stable while OUT_VALID=1 and OUT_READY=0.
REQ-021 Full with no pop: the push SHALL be dropped, contents unchanged, and Drop_Cnt incremented, saturating at 255.
REQ-022 Full with a simultaneous pop: the push SHALL be accepted and Count SHALL stay at DEPTH.
REQ-023 Empty with OUT_READY high: no pop occurs and Count is unchanged.
REQ-024 Simultaneous push and pop when non-empty and non-full SHALL leave Count unchanged.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH; Count SHALL never exceed DEPTH.
REQ-026 Count SHALL equal pushes minus pops since reset, excluding dropped pushes.

Reset
REQ-027 While RST=1 at an edge, the block SHALL clear the pointers and Count, drive OUT_VALID=0 and OUT_DATA=0, OUT_TAG=0, Drop_Cnt=0, and Multi_Err=0.
REQ-028 A flag asserted in the same cycle as RST SHALL be ignored.
REQ-029 RST asserted mid-operation SHALL discard all FIFO contents with no partial pop.
REQ-030 FIFO storage contents need not be reset; only the outputs listed in REQ-027 are defined.

Structure
REQ-031 A shared package SHALL hold the tag constants TAG_ARITH, TAG_LOGIC, TAG_CMP and TAG_SHIFT, and the 2-bit tag type.
REQ-032 The FIFO SHALL be a sub-module, alu_res_fifo, parameterized by width (RES_WIDTH+2) and DEPTH, with push/pop/full/empty/count ports.
REQ-033 Priority select, drop counter and Multi_Err SHALL live in alu_result_collector.

Verification
REQ-034 Reset, then Shift_Flag=1 with Shift_OUT=0x0014 for one cycle, OUT_READY=0 -> next cycle OUT_VALID=1, OUT_DATA=0x0014, OUT_TAG=3, Count=1.
REQ-035 Arith_Flag and Logic_Flag both 1 with Arith_OUT=0x00AA and Logic_OUT=0x0055 -> 0x00AA pushed with tag 0, Multi_Err=1 and held through later cycles.
REQ-036 OUT_READY=0, six consecutive single-flag pushes with DEPTH=4 -> Count=4, Drop_Cnt=2, head is the first value pushed.
REQ-037 FIFO full, then push and OUT_READY=1 in the same cycle -> Count stays 4, the oldest entry is popped, and the new value is at the tail.
REQ-038 300 pushes while full, no pops -> Drop_Cnt=255.
REQ-039 Count=3, RST=1 for one cycle with Cmp_Flag=1 -> Count=0, OUT_VALID=0, Drop_Cnt=0, and the CMP result is not stored.
